vdp_sprite_meta_dma: RTL and testbench
======================================

Name: vdp_sprite_meta_dma

Overview:
- Upstream feeder for the sprite core's metadata blocks (x_block, y_block, g_block).
- Copies a packed sprite attribute table from VRAM into the selected blocks through the existing meta_address / meta_write_data / meta_block_select / meta_we write port.
- The CPU no longer writes attributes one register at a time.
- Copies can be deferred to vblank so attribute updates never tear mid-frame.

Parameters:
- WAIT_VBLANK, 1: when 1, an accepted start holds in WAIT_VB until vblank=1; when 0, the copy begins immediately.
- VRAM_AW, 14: VRAM word address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  VRAM_AW  first VRAM word of the source table
- first_sprite  in  8  first destination sprite index
- sprite_count  in  9  sprites per block, 0..256; 0 = no-op
- block_mask  in  3  bit0 = x, bit1 = y, bit2 = g
- vblank  in  1  vertical blanking active
- busy  out  1  copy in progress, including WAIT_VB
- done  out  1  one-cycle completion pulse
- vram_read_req  out  1  read request, held until granted
- vram_read_address  out  VRAM_AW  requested word
- vram_read_grant  in  1  request accepted this cycle
- vram_read_data  in  32  returned word
- vram_data_valid  in  1  vram_read_data valid this cycle
- meta_address  out  8  sprite index to write
- meta_write_data  out  16  attribute halfword
- meta_block_select  out  3  one-hot block select
- meta_we  out  1  write strobe

Behaviour:
- Reset: async on reset_n low. All outputs 0, state IDLE, counters 0. Reset mid-copy aborts with no further meta_we and no done pulse.
- Operand capture: start, src_base, first_sprite, sprite_count and block_mask are captured in IDLE when start=1. They are ignored in all other states.
- Immediate completion: if sprite_count=0 or block_mask=0 at start, done pulses the next cycle and busy never asserts.
- Source layout: enabled blocks are concatenated in order x, y, g. Each block occupies ceil(sprite_count/2) consecutive words. Low half = even sprite, high half = odd sprite. The word address increments across blocks and wraps modulo 2^VRAM_AW.
- States:
  - IDLE: wait for start.
  - WAIT_VB: taken only if WAIT_VBLANK=1; leave when vblank=1.
  - REQ: vram_read_req=1 with address stable until vram_read_grant; then go to WAIT_DATA.
  - WAIT_DATA: wait for vram_data_valid, latch the 32-bit word, go to WR_LO.
  - WR_LO: write the low half.
  - WR_HI: write the high half, skipped if it would exceed sprite_count.
  - NEXT: select the next enabled block or finish.
  - FIN: done=1, busy=0, then IDLE.
- Outstanding reads: at most one. vram_data_valid outside WAIT_DATA is ignored.
- Write cycles: meta_we=1 for exactly one cycle in WR_LO/WR_HI.
  - meta_block_select is the one-hot value of the current block.
  - meta_address = first_sprite + sprite offset, 8-bit wrap (255 → 0).
  - meta_block_select is 0 whenever meta_we=0.
- Per-block restart: sprite offset resets to 0 and meta_address returns to first_sprite.
- Latency:
  - start → vram_read_req: 1 cycle (WAIT_VBLANK=0 or vblank already high).
  - vram_data_valid → first meta_we: 1 cycle.
  - Last write → done: 2 cycles (NEXT, FIN).
- busy: high from the cycle after an accepted start through the last NEXT; low in the done cycle.
- vblank may drop mid-copy; the copy continues (software sizes copies to fit).
- sprite_count=256: exactly 128 words per block; every index written once.
- Odd count: the final high half is read but not written.

Decomposition:
- Shared package vdp_sprite_pkg:
  - META_BLOCK_X=3'b001, META_BLOCK_Y=3'b010, META_BLOCK_G=3'b100
  - state enum for this block
  - SPRITE_COUNT_MAX=256
- No sub-module. Block iteration (lowest set bit of the remaining mask) is a small function in the package.

Test Plan:
- count=4, mask=3'b001, first=0x10, src=0x0100, WAIT_VBLANK=0, 2-cycle data latency:
  - exactly 2 reads (0x0100, 0x0101);
  - x writes to 0x10..0x13 with halves lo/hi in order;
  - done 2 cycles after the last write.
- count=3, mask=3'b111, src=0x3FFF:
  - reads 0x3FFF, 0x0000, 0x0001, 0x0002, 0x0003, 0x0004 (address wrap);
  - 9 writes, 3 per block in x, y, g order;
  - no write of the 4th halfword of any block.
- first=0xFE, count=4, mask=3'b100: g writes to indexes 0xFE, 0xFF, 0x00, 0x01.
- WAIT_VBLANK=1, vblank=0 for 50 cycles:
  - busy=1 and no vram_read_req for those cycles;
  - request appears 1 cycle after vblank rises;
  - second start while busy has no effect.
- Grant held off 5 cycles:
  - address and req stable throughout;
  - spurious vram_data_valid during REQ is ignored.
- count=0 → done next cycle, busy stays 0.
- reset_n low mid-WR_LO: meta_we falls immediately, no done pulse; a fresh start after release completes normally.

Source files
------------

// File: rtl/vdp_sprite_pkg.sv
// Shared types and constants for the sprite metadata DMA: block encodings,
// FSM state type and the block-iteration helper.
package vdp_sprite_pkg;

  localparam logic [2:0] META_BLOCK_X = 3'b001;
  localparam logic [2:0] META_BLOCK_Y = 3'b010;
  localparam logic [2:0] META_BLOCK_G = 3'b100;

  localparam int unsigned SPRITE_COUNT_MAX = 256;
  // Wide enough to hold SPRITE_COUNT_MAX itself, not just SPRITE_COUNT_MAX-1.
  localparam int unsigned SPRITE_CNT_W = $clog2(SPRITE_COUNT_MAX) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVb,
    StReq,
    StWaitData,
    StWrLo,
    StWrHi,
    StNext,
    StFin
  } dma_state_e;

  // Blocks are visited x, y, g: pick the lowest set bit of the remaining mask.
  function automatic logic [2:0] lowest_block(input logic [2:0] mask);
    if (mask[0]) return META_BLOCK_X;
    if (mask[1]) return META_BLOCK_Y;
    if (mask[2]) return META_BLOCK_G;
    return 3'b000;
  endfunction

endpackage

// File: rtl/vdp_sprite_meta_dma_if.sv
// VRAM read port and sprite metadata write port of the attribute DMA.
interface vdp_sprite_meta_dma_if #(
  parameter int unsigned VRAM_AW = 14
);

  logic               vram_read_req;
  logic [VRAM_AW-1:0] vram_read_address;
  logic               vram_read_grant;
  logic [31:0]        vram_read_data;
  logic               vram_data_valid;

  logic [7:0]         meta_address;
  logic [15:0]        meta_write_data;
  logic [2:0]         meta_block_select;
  logic               meta_we;

  modport master (
    output vram_read_req,
    output vram_read_address,
    input  vram_read_grant,
    input  vram_read_data,
    input  vram_data_valid,
    output meta_address,
    output meta_write_data,
    output meta_block_select,
    output meta_we
  );

  modport slave (
    input  vram_read_req,
    input  vram_read_address,
    output vram_read_grant,
    output vram_read_data,
    output vram_data_valid,
    input  meta_address,
    input  meta_write_data,
    input  meta_block_select,
    input  meta_we
  );

endinterface

// File: rtl/vdp_sprite_meta_dma.sv
// Copies a packed sprite attribute table from VRAM into the x/y/g metadata
// blocks, one 32-bit word (two sprites) at a time, optionally deferred to vblank.
module vdp_sprite_meta_dma
  import vdp_sprite_pkg::*;
#(
  parameter bit          WAIT_VBLANK = 1'b1,
  parameter int unsigned VRAM_AW     = 14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [VRAM_AW-1:0]      src_base,
  input  logic [7:0]              first_sprite,
  input  logic [SPRITE_CNT_W-1:0] sprite_count,
  input  logic [2:0]              block_mask,
  input  logic                    vblank,
  output logic                    busy,
  output logic                    done,
  vdp_sprite_meta_dma_if.master   bus
);

  dma_state_e              state_q, state_d;
  logic [VRAM_AW-1:0]      addr_q, addr_d;
  logic [15:0]             hi_q, hi_d;
  logic [SPRITE_CNT_W-1:0] offset_q, offset_d;
  logic [SPRITE_CNT_W-1:0] count_q, count_d;
  logic [7:0]              first_q, first_d;
  logic [2:0]              blk_q, blk_d;
  logic [2:0]              rem_q, rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [7:0]              maddr_q, maddr_d;
  logic [15:0]             mdata_q, mdata_d;
  logic [2:0]              msel_q, msel_d;

  logic [SPRITE_CNT_W:0]   hi_idx, nxt_idx;
  logic                    has_hi, has_more;
  logic [2:0]              start_blk, next_blk;

  assign hi_idx    = {1'b0, offset_q} + (SPRITE_CNT_W + 1)'(1);
  assign nxt_idx   = {1'b0, offset_q} + (SPRITE_CNT_W + 1)'(2);
  assign has_hi    = hi_idx < {1'b0, count_q};
  assign has_more  = nxt_idx < {1'b0, count_q};
  assign start_blk = lowest_block(block_mask);
  assign next_blk  = lowest_block(rem_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    offset_d = offset_q;
    count_d  = count_q;
    first_d  = first_q;
    blk_d    = blk_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    req_d    = 1'b0;
    we_d     = 1'b0;
    maddr_d  = 8'h00;
    mdata_d  = 16'h0000;
    msel_d   = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = src_base;
          first_d  = first_sprite;
          count_d  = sprite_count;
          offset_d = '0;
          blk_d    = start_blk;
          rem_d    = block_mask & ~start_blk;
          if (sprite_count == '0 || block_mask == 3'b000) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (WAIT_VBLANK && !vblank) begin
              state_d = StWaitVb;
            end else begin
              state_d = StReq;
              req_d   = 1'b1;
            end
          end
        end
      end
      StWaitVb: begin
        if (vblank) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        if (bus.vram_read_grant) state_d = StWaitData;
        else req_d = 1'b1;
      end
      StWaitData: begin
        if (bus.vram_data_valid) begin
          hi_d    = bus.vram_read_data[31:16];
          state_d = StWrLo;
          we_d    = 1'b1;
          msel_d  = blk_q;
          maddr_d = first_q + offset_q[7:0];
          mdata_d = bus.vram_read_data[15:0];
        end
      end
      StWrLo: begin
        // An odd count leaves the last high half unwritten.
        if (has_hi) begin
          state_d = StWrHi;
          we_d    = 1'b1;
          msel_d  = blk_q;
          maddr_d = first_q + hi_idx[7:0];
          mdata_d = hi_q;
        end else begin
          state_d = StNext;
        end
      end
      StWrHi: begin
        if (has_more) begin
          state_d  = StReq;
          req_d    = 1'b1;
          addr_d   = addr_q + VRAM_AW'(1);
          offset_d = nxt_idx[SPRITE_CNT_W-1:0];
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (rem_q != 3'b000) begin
          blk_d    = next_blk;
          rem_d    = rem_q & ~next_blk;
          offset_d = '0;
          addr_d   = addr_q + VRAM_AW'(1);
          state_d  = StReq;
          req_d    = 1'b1;
        end else begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      hi_q     <= '0;
      offset_q <= '0;
      count_q  <= '0;
      first_q  <= '0;
      blk_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      msel_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      offset_q <= offset_d;
      count_q  <= count_d;
      first_q  <= first_d;
      blk_q    <= blk_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      msel_q   <= msel_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign bus.vram_read_req     = req_q;
  assign bus.vram_read_address = addr_q;
  assign bus.meta_we           = we_q;
  assign bus.meta_address      = maddr_q;
  assign bus.meta_write_data   = mdata_q;
  assign bus.meta_block_select = msel_q;

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Bench for the sprite metadata DMA: a queue-based copy model plus a VRAM
// responder, with two DUTs (immediate and vblank-deferred) behind one view.
module tb_vdp_sprite_meta_dma;
  import vdp_sprite_pkg::*;

  localparam int unsigned AW = 14;

  typedef struct packed {
    logic [2:0]  sel;
    logic [7:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, vblank, use_vb;
  logic [AW-1:0] src_base;
  logic [7:0]    first_sprite;
  logic [8:0]    sprite_count;
  logic [2:0]    block_mask;
  logic          busy0, busy1, done0, done1;
  logic          grant, valid;
  logic [31:0]   rdata;

  vdp_sprite_meta_dma_if #(.VRAM_AW(AW)) bus0 ();
  vdp_sprite_meta_dma_if #(.VRAM_AW(AW)) bus1 ();

  vdp_sprite_meta_dma #(.WAIT_VBLANK(1'b0), .VRAM_AW(AW)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start & ~use_vb), .src_base(src_base),
    .first_sprite(first_sprite), .sprite_count(sprite_count), .block_mask(block_mask),
    .vblank(vblank), .busy(busy0), .done(done0), .bus(bus0)
  );

  vdp_sprite_meta_dma #(.WAIT_VBLANK(1'b1), .VRAM_AW(AW)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start & use_vb), .src_base(src_base),
    .first_sprite(first_sprite), .sprite_count(sprite_count), .block_mask(block_mask),
    .vblank(vblank), .busy(busy1), .done(done1), .bus(bus1)
  );

  assign bus0.vram_read_grant = grant & ~use_vb;
  assign bus1.vram_read_grant = grant & use_vb;
  assign bus0.vram_data_valid = valid & ~use_vb;
  assign bus1.vram_data_valid = valid & use_vb;
  assign bus0.vram_read_data  = rdata;
  assign bus1.vram_read_data  = rdata;

  logic          m_req, m_we, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_sel;
  logic [7:0]    m_maddr;
  logic [15:0]   m_mdata;
  assign m_req   = use_vb ? bus1.vram_read_req     : bus0.vram_read_req;
  assign m_addr  = use_vb ? bus1.vram_read_address : bus0.vram_read_address;
  assign m_we    = use_vb ? bus1.meta_we           : bus0.meta_we;
  assign m_sel   = use_vb ? bus1.meta_block_select : bus0.meta_block_select;
  assign m_maddr = use_vb ? bus1.meta_address      : bus0.meta_address;
  assign m_mdata = use_vb ? bus1.meta_write_data   : bus0.meta_write_data;
  assign m_busy  = use_vb ? busy1 : busy0;
  assign m_done  = use_vb ? done1 : done0;

  int            n_chk = 0, n_fail = 0;
  int            cyc = 0, last_wr = -100;
  bit            wr_seen, chk_en, spurious;
  int            grant_dly, data_lat;
  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {2'b10, a, 2'b01, a ^ 14'h2A5A};
  endfunction

  // Enabled blocks are concatenated x, y, g; each holds ceil(count/2) words.
  task automatic build_model(input logic [AW-1:0] src, input logic [7:0] first,
                             input int count, input logic [2:0] mask);
    int            w;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    wr_t           e;
    w = 0;
    exp_rd.delete();
    exp_wr.delete();
    for (int b = 0; b < 3; b++) begin
      if (mask[b]) begin
        for (int k = 0; k < (count + 1) / 2; k++) begin
          a  = src + AW'(w);
          wd = mem_word(a);
          exp_rd.push_back(a);
          for (int h = 0; h < 2; h++) begin
            if (2 * k + h < count) begin
              e.sel  = 3'(1 << b);
              e.idx  = 8'(int'(first) + 2 * k + h);
              e.data = (h == 1) ? wd[31:16] : wd[15:0];
              exp_wr.push_back(e);
            end
          end
          w++;
        end
      end
    end
  endtask

  // VRAM responder: grant after grant_dly stalled cycles, data data_lat cycles later.
  initial begin : vram
    int            lat, gw;
    logic [AW-1:0] pend;
    grant = 1'b0; valid = 1'b0; rdata = '0; lat = 0; gw = 0; pend = '0;
    forever begin
      @(negedge clk);
      grant = 1'b0; valid = 1'b0; rdata = '0;
      if (!reset_n) begin
        lat = 0;
        gw  = grant_dly;
        continue;
      end
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          valid = 1'b1;
          rdata = mem_word(pend);
        end
      end
      if (m_req) begin
        if (gw == 0) begin
          grant = 1'b1;
          pend  = m_addr;
          lat   = data_lat;
        end else begin
          gw--;
          if (spurious) begin
            valid = 1'b1;
            rdata = 32'hBAD0_BAD0;
          end
        end
      end else begin
        gw = grant_dly;
      end
    end
  end

  initial begin : cmp
    logic          prev_req, prev_gnt;
    logic [AW-1:0] prev_addr;
    wr_t           e;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset_n && chk_en) begin
        if (!m_we) check("sel_zero_without_we", 64'(m_sel), 0);
        if (m_we) begin
          check("write_expected", 64'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_sel", 64'(m_sel), 64'(e.sel));
            check("wr_idx", 64'(m_maddr), 64'(e.idx));
            check("wr_data", 64'(m_mdata), 64'(e.data));
          end
          check("busy_during_write", 64'(m_busy), 1);
          last_wr = cyc;
          wr_seen = 1'b1;
        end
        if (prev_req && !prev_gnt) begin
          check("req_held", 64'(m_req), 1);
          check("addr_held", 64'(m_addr), 64'(prev_addr));
        end
        if (m_req) check("busy_during_req", 64'(m_busy), 1);
        if (m_req && grant) begin
          check("read_expected", 64'(exp_rd.size() != 0), 1);
          if (exp_rd.size() != 0) check("rd_addr", 64'(m_addr), 64'(exp_rd.pop_front()));
        end
        if (m_done) begin
          check("busy_low_at_done", 64'(m_busy), 0);
          if (wr_seen) check("done_after_last_write", 64'(cyc - last_wr), 2);
        end
      end
      prev_req  = m_req;
      prev_gnt  = grant;
      prev_addr = m_addr;
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!m_done && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 64'(m_done), 1);
    check({tag, "_reads_drained"}, 64'(exp_rd.size()), 0);
    check({tag, "_writes_drained"}, 64'(exp_wr.size()), 0);
  endtask

  task automatic run_copy(input logic vb, input logic [AW-1:0] src, input logic [7:0] first,
                          input int count, input logic [2:0] mask, input int gdly,
                          input int dlat, input bit spur, input string tag);
    use_vb = vb; grant_dly = gdly; data_lat = dlat; spurious = spur;
    build_model(src, first, count, mask);
    wr_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; src_base = src; first_sprite = first;
    sprite_count = 9'(count); block_mask = mask;
    @(negedge clk);
    start = 1'b0;
    #1;
    if (count == 0 || mask == 3'b000) begin
      check({tag, "_noop_done"}, 64'(m_done), 1);
      check({tag, "_noop_busy"}, 64'(m_busy), 0);
      @(negedge clk);
      #1;
      check({tag, "_noop_done_once"}, 64'(m_done), 0);
      check({tag, "_noop_busy_after"}, 64'(m_busy), 0);
    end else begin
      check({tag, "_req_latency"}, 64'(m_req), 1);
      check({tag, "_busy_after_start"}, 64'(m_busy), 1);
      wait_done(tag);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset_n = 1'b0; start = 1'b0; vblank = 1'b1; use_vb = 1'b0;
    src_base = '0; first_sprite = '0; sprite_count = '0; block_mask = '0;
    chk_en = 1'b0; spurious = 1'b0; grant_dly = 0; data_lat = 2; wr_seen = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'({busy0, busy1}), 0);
    check("rst_done", 64'({done0, done1}), 0);
    check("rst_req", 64'({bus0.vram_read_req, bus1.vram_read_req}), 0);
    check("rst_we", 64'({bus0.meta_we, bus1.meta_we}), 0);
    check("rst_sel", 64'({bus0.meta_block_select, bus1.meta_block_select}), 0);
    check("rst_addr", 64'({bus0.vram_read_address, bus1.vram_read_address}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Basic x-only copy; pin the model against hand-computed values first.
    build_model(14'h0100, 8'h10, 4, 3'b001);
    check("model_t1_reads", 64'(exp_rd.size()), 2);
    check("model_t1_rd0", 64'(exp_rd[0]), 64'h0100);
    check("model_t1_rd1", 64'(exp_rd[1]), 64'h0101);
    check("model_t1_last_idx", 64'(exp_wr[3].idx), 64'h13);
    run_copy(1'b0, 14'h0100, 8'h10, 4, 3'b001, 0, 2, 1'b0, "t1");

    // Odd count across all blocks with source address wrap.
    build_model(14'h3FFF, 8'h00, 3, 3'b111);
    check("model_t2_reads", 64'(exp_rd.size()), 6);
    check("model_t2_wrap", 64'(exp_rd[1]), 64'h0000);
    check("model_t2_writes", 64'(exp_wr.size()), 9);
    run_copy(1'b0, 14'h3FFF, 8'h00, 3, 3'b111, 0, 1, 1'b0, "t2");

    // Destination index wrap in the g block.
    build_model(14'h0050, 8'hFE, 4, 3'b100);
    check("model_t3_idx2", 64'(exp_wr[2].idx), 64'h00);
    check("model_t3_sel", 64'(exp_wr[0].sel), 64'(META_BLOCK_G));
    run_copy(1'b0, 14'h0050, 8'hFE, 4, 3'b100, 0, 2, 1'b0, "t3");

    // Grant held off with spurious data-valid while requesting.
    run_copy(1'b0, 14'h0010, 8'h80, 5, 3'b011, 5, 3, 1'b1, "t4");

    // Full 256-sprite blocks.
    run_copy(1'b0, 14'h1000, 8'h00, SPRITE_COUNT_MAX, 3'b101, 0, 1, 1'b0, "t5");

    // No-op starts.
    run_copy(1'b0, 14'h0200, 8'h00, 0, 3'b111, 0, 2, 1'b0, "t6a");
    run_copy(1'b0, 14'h0200, 8'h00, 5, 3'b000, 0, 2, 1'b0, "t6b");

    // Vblank-deferred copy on the WAIT_VBLANK DUT, with an ignored second start.
    use_vb = 1'b1; grant_dly = 0; data_lat = 2; spurious = 1'b0; wr_seen = 1'b0;
    build_model(14'h0200, 8'h40, 2, 3'b010);
    vblank = 1'b0;
    @(negedge clk);
    start = 1'b1; src_base = 14'h0200; first_sprite = 8'h40;
    sprite_count = 9'd2; block_mask = 3'b010;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      check("vb_busy_waiting", 64'(m_busy), 1);
      check("vb_no_req_waiting", 64'(m_req), 0);
      @(negedge clk);
      start = (i == 20);
      if (i == 20) begin
        src_base = 14'h3000; first_sprite = 8'h00; sprite_count = 9'd7; block_mask = 3'b111;
      end
    end
    vblank = 1'b1;
    #1;
    check("vb_req_not_early", 64'(m_req), 0);
    @(negedge clk);
    #1;
    check("vb_req_latency", 64'(m_req), 1);
    @(negedge clk);
    vblank = 1'b0;
    #1;
    wait_done("vb");
    vblank = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the first write cycle of a copy.
    use_vb = 1'b0; grant_dly = 0; data_lat = 2; wr_seen = 1'b0;
    build_model(14'h0400, 8'h20, 4, 3'b011);
    @(negedge clk);
    start = 1'b1; src_base = 14'h0400; first_sprite = 8'h20;
    sprite_count = 9'd4; block_mask = 3'b011;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    #1;
    while (!m_we && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_mid_reached_write", 64'(m_we), 1);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_we_low", 64'(m_we), 0);
    check("rst_mid_sel_low", 64'(m_sel), 0);
    check("rst_mid_busy_low", 64'(m_busy), 0);
    exp_rd.delete();
    exp_wr.delete();
    wr_seen = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("rst_mid_no_done", 64'(m_done), 0);
      check("rst_mid_no_write", 64'(m_we), 0);
      @(negedge clk);
    end
    run_copy(1'b0, 14'h0400, 8'h20, 4, 3'b011, 0, 2, 1'b0, "t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
